// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register sitting in front of the EX-stage ALU.
// Captures decoded operands/control, decodes the 6-bit ALU operation code,
// forwards EX/MEM and MEM/WB results into the ALU operands and detects
// load-use hazards.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_id_*                  decoded instruction from ID
//   i_flush                 kill the instruction entering EX
//   i_stall_in              downstream stall, hold EX contents
//   i_exmem_*, i_memwb_*    forwarding sources
//   o_ex_*                  registered EX control/state
//   o_ex_src1/src2/store_data  forwarded operands (combinational)
//   o_hazard_stall          load-use stall request (combinational)
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_W-1:0]  i_id_rs,
    input  logic [REG_W-1:0]  i_id_rt,
    input  logic [REG_W-1:0]  i_id_rd,
    input  logic [DATA_W-1:0] i_id_rs_data,
    input  logic [DATA_W-1:0] i_id_rt_data,
    input  logic [DATA_W-1:0] i_id_imm,
    input  logic              i_id_alu_src,
    input  logic [1:0]        i_id_alu_op,
    input  logic [5:0]        i_id_funct,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_id_mem_write,
    input  logic              i_flush,
    input  logic              i_stall_in,
    input  logic              i_exmem_reg_write,
    input  logic [REG_W-1:0]  i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [REG_W-1:0]  i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic              o_ex_valid,
    output logic [REG_W-1:0]  o_ex_rd,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic [5:0]        o_ex_operation,
    output logic              o_ex_illegal,
    output logic [DATA_W-1:0] o_ex_src1,
    output logic [DATA_W-1:0] o_ex_src2,
    output logic [DATA_W-1:0] o_ex_store_data,
    output logic              o_hazard_stall
);

    localparam int unsigned OP_W = 6;
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(14);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(21);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(28);

    logic              r_valid;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic              r_alu_src;
    logic [OP_W-1:0]   r_operation;
    logic              r_illegal;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [OP_W-1:0]   w_dec_op;
    logic              w_dec_bad;
    logic              w_hazard_stall;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // ALU operation decode from alu_op / funct
    always_comb begin
        w_dec_op  = '0;
        w_dec_bad = 1'b0;
        case (i_id_alu_op)
            2'b00: w_dec_op = OP_ADD;
            2'b01: w_dec_op = OP_SUB;
            2'b11: w_dec_op = OP_OR;
            default: begin
                case (i_id_funct)
                    6'h20:   w_dec_op = OP_ADD;
                    6'h22:   w_dec_op = OP_SUB;
                    6'h24:   w_dec_op = OP_AND;
                    6'h25:   w_dec_op = OP_OR;
                    default: w_dec_bad = 1'b1;
                endcase
            end
        endcase
    end

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        w_hazard_stall = r_valid && r_mem_read && (r_rd != '0) && i_id_valid &&
                         ((r_rd == i_id_rs) || (r_rd == i_id_rt));
    end

    // Operand forwarding, EX/MEM takes priority over MEM/WB; r0 never forwards
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (i_exmem_reg_write && (i_exmem_rd == r_rs) && (r_rs != '0))
            w_fwd_rs = i_exmem_result;
        else if (i_memwb_reg_write && (i_memwb_rd == r_rs) && (r_rs != '0))
            w_fwd_rs = i_memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (i_exmem_reg_write && (i_exmem_rd == r_rt) && (r_rt != '0))
            w_fwd_rt = i_exmem_result;
        else if (i_memwb_reg_write && (i_memwb_rd == r_rt) && (r_rt != '0))
            w_fwd_rt = i_memwb_result;
    end

    // Pipeline register: reset > flush > hold > hazard bubble > load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_operation <= '0;
            r_illegal   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (i_flush || (!i_stall_in && w_hazard_stall)) begin
            // Bubble: data stays, control cleared so nothing is committed
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!i_stall_in) begin
            r_valid     <= i_id_valid;
            r_rs        <= i_id_rs;
            r_rt        <= i_id_rt;
            r_rd        <= i_id_rd;
            r_rs_data   <= i_id_rs_data;
            r_rt_data   <= i_id_rt_data;
            r_imm       <= i_id_imm;
            r_alu_src   <= i_id_alu_src;
            r_operation <= w_dec_op;
            r_illegal   <= i_id_valid && w_dec_bad;
            // Illegal funct must never write the register file
            r_reg_write <= i_id_valid && i_id_reg_write && !w_dec_bad;
            r_mem_read  <= i_id_valid && i_id_mem_read;
            r_mem_write <= i_id_valid && i_id_mem_write;
        end
    end

    assign o_ex_valid      = r_valid;
    assign o_ex_rd         = r_rd;
    assign o_ex_reg_write  = r_reg_write;
    assign o_ex_mem_read   = r_mem_read;
    assign o_ex_mem_write  = r_mem_write;
    assign o_ex_operation  = r_operation;
    assign o_ex_illegal    = r_illegal;
    assign o_ex_src1       = w_fwd_rs;
    assign o_ex_src2       = r_alu_src ? r_imm : w_fwd_rt;
    assign o_ex_store_data = w_fwd_rt;
    assign o_hazard_stall  = w_hazard_stall;

endmodule
